// File: rtl/gba_sdram_arbiter_pkg.sv
// rtl/gba_sdram_arbiter_pkg.sv - shared widths, FSM states and port-rotation helper for the SDRAM arbiter
package gba_sdram_arbiter_pkg;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int PORT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
        return (p >= PORT_W'(NREQ - 1)) ? '0 : p + PORT_W'(1);
    endfunction

endpackage

// File: rtl/gba_sdram_arbiter_rr_pick.sv
// rtl/gba_sdram_arbiter_rr_pick.sv - combinational round-robin select starting after last_grant
module gba_rr_pick
    import gba_sdram_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]   pending_i,
    input  logic [PORT_W-1:0] last_grant_i,
    output logic [PORT_W-1:0] grant_o,
    output logic              valid_o
);

    logic [PORT_W-1:0] idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = last_grant_i;
        for (int k = 0; k < NREQ; k++) begin
            idx = next_port(idx);
            if (!valid_o && pending_i[idx]) begin
                grant_o = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gba_sdram_arbiter.sv
// rtl/gba_sdram_arbiter.sv - three-port round-robin arbiter in front of a single SDRAM controller port
module gba_sdram_arbiter
    import gba_sdram_arbiter_pkg::*;
#(
    parameter int NREQ    = gba_sdram_arbiter_pkg::NREQ,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NREQ-1:0]               req_i,
    input  logic [NREQ-1:0]               req_rnw_i,
    input  logic [NREQ-1:0][ADDR_W-1:0]   req_addr_i,
    input  logic [NREQ-1:0][DATA_W-1:0]   req_din_i,
    input  logic [NREQ-1:0]               req_cancel_i,
    output logic [NREQ-1:0]               req_ready_o,
    output logic [DATA_W-1:0]             req_dout_o,
    output logic [NREQ-1:0]               req_overrun_o,
    output logic                          timeout_err_o,
    output logic                          mem_req_o,
    output logic                          mem_rnw_o,
    output logic                          mem_cancel_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_din_o,
    input  logic                          mem_ready_i,
    input  logic                          mem_ready16_i,
    input  logic [DATA_W-1:0]             mem_dout_i
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e                      state_q;
    logic [NREQ-1:0]             pending_q, pending_d;
    logic [NREQ-1:0]             busy, accept;
    logic [NREQ-1:0][ADDR_W-1:0] cap_addr_q;
    logic [NREQ-1:0][DATA_W-1:0] cap_din_q;
    logic [NREQ-1:0]             cap_rnw_q;
    logic [NREQ-1:0]             req_overrun_q;
    logic [PORT_W-1:0]           last_grant_q, grant_q, pick_idx;
    logic                        pick_valid, do_grant, wait_cancel;
    logic [CW-1:0]               wait_cnt_q;
    logic [NREQ-1:0]             req_ready_q;
    logic [DATA_W-1:0]           req_dout_q;
    logic                        timeout_q;
    logic                        mem_req_q, mem_rnw_q, mem_cancel_q;
    logic [ADDR_W-1:0]           mem_addr_q;
    logic [DATA_W-1:0]           mem_din_q;
    logic                        unused_ready16;

    // The controller's 16-bit completion is never consumed by this arbiter.
    assign unused_ready16 = mem_ready16_i;

    gba_rr_pick u_pick (
        .pending_i    (pending_q),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_idx),
        .valid_o      (pick_valid)
    );

    assign do_grant    = (state_q == IDLE) && pick_valid;
    assign wait_cancel = req_cancel_i[grant_q] & mem_rnw_q;

    // A port is busy while pending or in flight; a port whose req_ready is
    // pulsing is already back in IDLE and can take a fresh request.
    always_comb begin
        busy      = '0;
        accept    = '0;
        pending_d = '0;
        for (int p = 0; p < NREQ; p++) begin
            busy[p]      = pending_q[p] | ((state_q != IDLE) && (grant_q == PORT_W'(p)));
            accept[p]    = req_i[p] & ~busy[p];
            pending_d[p] = accept[p] |
                           (pending_q[p] & ~req_cancel_i[p] &
                            ~(do_grant && (pick_idx == PORT_W'(p))));
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_q     <= '0;
            cap_addr_q    <= '0;
            cap_din_q     <= '0;
            cap_rnw_q     <= '1;
            req_overrun_q <= '0;
        end else begin
            pending_q     <= pending_d;
            req_overrun_q <= req_i & busy;
            for (int p = 0; p < NREQ; p++) begin
                if (accept[p]) begin
                    cap_addr_q[p] <= req_addr_i[p];
                    cap_din_q[p]  <= req_din_i[p];
                    cap_rnw_q[p]  <= req_rnw_i[p];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_W'(NREQ - 1);
            grant_q      <= '0;
            wait_cnt_q   <= '0;
            req_ready_q  <= '0;
            req_dout_q   <= '0;
            timeout_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_rnw_q    <= 1'b1;
            mem_cancel_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
        end else begin
            mem_req_q    <= 1'b0;
            mem_cancel_q <= 1'b0;
            timeout_q    <= 1'b0;
            req_ready_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q      <= pick_idx;
                        last_grant_q <= pick_idx;
                        mem_addr_q   <= cap_addr_q[pick_idx];
                        mem_din_q    <= cap_din_q[pick_idx];
                        mem_rnw_q    <= cap_rnw_q[pick_idx];
                        mem_req_q    <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt_q <= CW'(1);
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (wait_cancel) begin
                        mem_cancel_q <= 1'b1;
                        state_q      <= IDLE;
                    end else if (mem_ready_i) begin
                        req_ready_q[grant_q] <= 1'b1;
                        req_dout_q           <= mem_dout_i;
                        state_q              <= IDLE;
                    end else if (wait_cnt_q == CW'(TIMEOUT)) begin
                        timeout_q    <= 1'b1;
                        mem_cancel_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign req_dout_o    = req_dout_q;
    assign req_overrun_o = req_overrun_q;
    assign timeout_err_o = timeout_q;
    assign mem_req_o     = mem_req_q;
    assign mem_rnw_o     = mem_rnw_q;
    assign mem_cancel_o  = mem_cancel_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_din_o     = mem_din_q;

endmodule

// File: tb/tb_gba_sdram_arbiter.sv
// tb/tb_gba_sdram_arbiter.sv - directed self-checking bench for gba_sdram_arbiter
module tb_gba_sdram_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int TO = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [2:0]         req, req_rnw, req_cancel;
    logic [2:0][AW-1:0] req_addr;
    logic [2:0][DW-1:0] req_din;
    logic [2:0]         req_ready, req_overrun;
    logic [DW-1:0]      req_dout;
    logic               timeout_err, mem_req, mem_rnw, mem_cancel;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_din;
    logic               mem_ready, mem_ready16;
    logic [DW-1:0]      mem_dout;

    int checks = 0;
    int failures = 0;
    int n_memreq, n_cancel, n_timeout;
    int n_ready[3];
    int n_ovr[3];

    always #5 clk = ~clk;

    gba_sdram_arbiter #(.NREQ(3), .TIMEOUT(TO)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .req_i         (req),
        .req_rnw_i     (req_rnw),
        .req_addr_i    (req_addr),
        .req_din_i     (req_din),
        .req_cancel_i  (req_cancel),
        .req_ready_o   (req_ready),
        .req_dout_o    (req_dout),
        .req_overrun_o (req_overrun),
        .timeout_err_o (timeout_err),
        .mem_req_o     (mem_req),
        .mem_rnw_o     (mem_rnw),
        .mem_cancel_o  (mem_cancel),
        .mem_addr_o    (mem_addr),
        .mem_din_o     (mem_din),
        .mem_ready_i   (mem_ready),
        .mem_ready16_i (mem_ready16),
        .mem_dout_i    (mem_dout)
    );

    always @(negedge clk) begin
        if (mem_req === 1'b1) n_memreq++;
        if (mem_cancel === 1'b1) n_cancel++;
        if (timeout_err === 1'b1) n_timeout++;
        for (int p = 0; p < 3; p++) begin
            if (req_ready[p] === 1'b1) n_ready[p]++;
            if (req_overrun[p] === 1'b1) n_ovr[p]++;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_mon();
        #1;
        n_memreq = 0; n_cancel = 0; n_timeout = 0;
        for (int p = 0; p < 3; p++) begin
            n_ready[p] = 0;
            n_ovr[p] = 0;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req = '0; req_rnw = '0; req_cancel = '0; req_addr = '0; req_din = '0;
        mem_ready = 1'b0; mem_ready16 = 1'b0; mem_dout = '0;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    task automatic send(input int p, input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p] = 1'b1; req_rnw[p] = rnw; req_addr[p] = a; req_din[p] = d;
        step();
        req[p] = 1'b0;
    endtask

    task automatic wait_memreq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic respond(input int delay, input logic [DW-1:0] data);
        repeat (delay) step();
        mem_ready = 1'b1; mem_dout = data;
        step();
        mem_ready = 1'b0; mem_dout = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_req_ready got %b expected 000", req_ready); end
        checks++; if (req_overrun !== 3'b000) begin failures++; $display("FAIL reset_overrun got %b expected 000", req_overrun); end
        checks++; if ({mem_req, mem_cancel, timeout_err} !== 3'b000) begin failures++; $display("FAIL reset_pulses got %b expected 000", {mem_req, mem_cancel, timeout_err}); end
        checks++; if (mem_rnw !== 1'b1) begin failures++; $display("FAIL reset_mem_rnw got %b expected 1", mem_rnw); end
        checks++; if ({mem_addr, mem_din, req_dout} !== '0) begin failures++; $display("FAIL reset_data got %h %h %h expected 0", mem_addr, mem_din, req_dout); end
    endtask

    task automatic test_single_read();
        bit ok;
        clear_mon();
        send(0, 1'b1, 26'h0001000, '0);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL read_early_memreq got %b expected 0", mem_req); end
        step();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL read_latency got %b expected 1", mem_req); end
        checks++; if (mem_addr !== 26'h0001000 || mem_rnw !== 1'b1) begin failures++; $display("FAIL read_addr got %h/%b expected 0001000/1", mem_addr, mem_rnw); end
        respond(5, 32'hDEADBEEF);
        checks++; if (req_ready !== 3'b001 || req_dout !== 32'hDEADBEEF) begin failures++; $display("FAIL read_ready got %b/%h expected 001/deadbeef", req_ready, req_dout); end
        repeat (4) step();
        checks++; if (n_memreq != 1 || n_ready[0] != 1) begin failures++; $display("FAIL read_counts got memreq=%0d ready=%0d expected 1 1", n_memreq, n_ready[0]); end
        ok = 1'b1;
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [AW-1:0] exp_a;
        logic [2:0]    exp_r;
        apply_reset();
        req = 3'b111; req_rnw = 3'b111;
        req_addr[0] = 26'h100; req_addr[1] = 26'h200; req_addr[2] = 26'h300;
        step();
        req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            exp_a = AW'((i + 1) * 'h100);
            exp_r = 3'(1 << i);
            wait_memreq(ok);
            checks++; if (ok !== 1'b1 || mem_addr !== exp_a) begin failures++; $display("FAIL rr_grant%0d got ok=%b addr=%h expected addr=%h", i, ok, mem_addr, exp_a); end
            respond(2, 32'hA000_0000 + DW'(i));
            checks++; if (req_ready !== exp_r || req_dout !== 32'hA000_0000 + DW'(i)) begin failures++; $display("FAIL rr_ready%0d got %b/%h expected %b", i, req_ready, req_dout, exp_r); end
        end
    endtask

    task automatic test_cancel_read();
        bit ok;
        apply_reset();
        clear_mon();
        req[1] = 1'b1; req[2] = 1'b1; req_rnw[1] = 1'b1; req_rnw[2] = 1'b1;
        req_addr[1] = 26'h11; req_addr[2] = 26'h22;
        step();
        req = '0;
        wait_memreq(ok);
        checks++; if (ok !== 1'b1 || mem_addr !== 26'h11) begin failures++; $display("FAIL cancel_first got ok=%b addr=%h expected 11", ok, mem_addr); end
        repeat (2) step();
        req_cancel[1] = 1'b1;
        step();
        req_cancel[1] = 1'b0;
        checks++; if (mem_cancel !== 1'b1 || req_ready !== 3'b000) begin failures++; $display("FAIL cancel_pulse got cancel=%b ready=%b expected 1/000", mem_cancel, req_ready); end
        wait_memreq(ok);
        checks++; if (ok !== 1'b1 || mem_addr !== 26'h22) begin failures++; $display("FAIL cancel_next got ok=%b addr=%h expected 22", ok, mem_addr); end
        respond(1, 32'h2222);
        checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL cancel_port2 got %b expected 100", req_ready); end
        repeat (3) step();
        checks++; if (n_ready[1] != 0 || n_cancel != 1) begin failures++; $display("FAIL cancel_counts got ready1=%0d cancel=%0d expected 0 1", n_ready[1], n_cancel); end
    endtask

    task automatic test_cancel_write();
        bit ok;
        send(0, 1'b0, 26'h40, 32'h12345678);
        wait_memreq(ok);
        checks++; if (ok !== 1'b1 || mem_rnw !== 1'b0 || mem_din !== 32'h12345678) begin failures++; $display("FAIL wr_issue got ok=%b rnw=%b din=%h expected 0/12345678", ok, mem_rnw, mem_din); end
        step();
        req_cancel[0] = 1'b1;
        step();
        req_cancel[0] = 1'b0;
        checks++; if (mem_cancel !== 1'b0) begin failures++; $display("FAIL wr_cancel_ignored got %b expected 0", mem_cancel); end
        respond(1, '0);
        checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL wr_ready got %b expected 001", req_ready); end
    endtask

    task automatic test_cancel_vs_ready();
        bit ok;
        send(0, 1'b1, 26'h50, '0);
        wait_memreq(ok);
        step();
        mem_ready = 1'b1; mem_dout = 32'h5555; req_cancel[0] = 1'b1;
        step();
        mem_ready = 1'b0; mem_dout = '0; req_cancel[0] = 1'b0;
        checks++; if (ok !== 1'b1 || req_ready !== 3'b000 || mem_cancel !== 1'b1) begin failures++; $display("FAIL cancel_wins got ok=%b ready=%b cancel=%b expected 1/000/1", ok, req_ready, mem_cancel); end
    endtask

    task automatic test_cancel_pending();
        bit ok;
        send(0, 1'b1, 26'h60, '0);
        wait_memreq(ok);
        clear_mon();
        send(1, 1'b1, 26'h61, '0);
        req_cancel[1] = 1'b1;
        step();
        req_cancel[1] = 1'b0;
        respond(1, 32'h6060);
        repeat (8) step();
        checks++; if (ok !== 1'b1 || n_memreq != 0 || n_ready[1] != 0 || n_ready[0] != 1) begin failures++; $display("FAIL cancel_pending got ok=%b memreq=%0d ready1=%0d ready0=%0d expected 1 0 0 1", ok, n_memreq, n_ready[1], n_ready[0]); end
    endtask

    task automatic test_cancel_with_req();
        req[1] = 1'b1; req_cancel[1] = 1'b1; req_rnw[1] = 1'b1; req_addr[1] = 26'h77;
        step();
        req[1] = 1'b0; req_cancel[1] = 1'b0;
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 26'h77) begin failures++; $display("FAIL cancel_with_req got %b/%h expected 1/77", mem_req, mem_addr); end
        respond(1, 32'h7777);
        checks++; if (req_ready !== 3'b010 || req_dout !== 32'h7777) begin failures++; $display("FAIL cancel_with_req_ready got %b/%h expected 010/7777", req_ready, req_dout); end
    endtask

    task automatic test_overrun();
        bit ok;
        clear_mon();
        send(0, 1'b1, 26'h80, '0);
        wait_memreq(ok);
        step();
        send(0, 1'b1, 26'h81, '0);
        checks++; if (ok !== 1'b1 || req_overrun !== 3'b001) begin failures++; $display("FAIL overrun_pulse got ok=%b ovr=%b expected 001", ok, req_overrun); end
        step();
        checks++; if (req_overrun !== 3'b000) begin failures++; $display("FAIL overrun_one_cycle got %b expected 000", req_overrun); end
        respond(2, 32'h8080);
        repeat (6) step();
        checks++; if (n_ready[0] != 1 || n_ovr[0] != 1 || n_memreq != 1) begin failures++; $display("FAIL overrun_counts got ready=%0d ovr=%0d memreq=%0d expected 1 1 1", n_ready[0], n_ovr[0], n_memreq); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        send(0, 1'b1, 26'h90, '0);
        wait_memreq(ok);
        respond(1, 32'h9090);
        req[0] = 1'b1; req_addr[0] = 26'h91;
        step();
        req[0] = 1'b0;
        checks++; if (ok !== 1'b1 || req_overrun !== 3'b000) begin failures++; $display("FAIL b2b_no_overrun got ok=%b ovr=%b expected 000", ok, req_overrun); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 26'h91) begin failures++; $display("FAIL b2b_second got %b/%h expected 1/91", mem_req, mem_addr); end
        respond(1, 32'h9191);
        checks++; if (req_ready !== 3'b001 || req_dout !== 32'h9191) begin failures++; $display("FAIL b2b_ready got %b/%h expected 001/9191", req_ready, req_dout); end
    endtask

    task automatic test_timeout();
        bit ok;
        apply_reset();
        clear_mon();
        send(2, 1'b1, 26'hA0, '0);
        wait_memreq(ok);
        repeat (TO) step();
        checks++; if (ok !== 1'b1 || n_timeout != 0 || timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_early got ok=%b n=%0d err=%b expected 0", ok, n_timeout, timeout_err); end
        step();
        checks++; if (timeout_err !== 1'b1 || mem_cancel !== 1'b1) begin failures++; $display("FAIL timeout_pulse got err=%b cancel=%b expected 1 1", timeout_err, mem_cancel); end
        send(1, 1'b1, 26'hA1, '0);
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_one_cycle got %b expected 0", timeout_err); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 26'hA1) begin failures++; $display("FAIL timeout_idle got %b/%h expected 1/a1", mem_req, mem_addr); end
        respond(1, 32'hA1A1);
        checks++; if (req_ready !== 3'b010 || n_ready[2] != 0) begin failures++; $display("FAIL timeout_after got %b ready2=%0d expected 010 0", req_ready, n_ready[2]); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        clear_mon();
        send(0, 1'b1, 26'hB0, '0);
        wait_memreq(ok);
        step();
        reset = 1'b1;
        #1;
        checks++; if (ok !== 1'b1 || {mem_req, mem_cancel, mem_rnw} !== 3'b001 || {mem_addr, mem_din, req_dout} !== '0) begin failures++; $display("FAIL rst_wait_outputs got req/cancel/rnw=%b%b%b addr=%h dout=%h", mem_req, mem_cancel, mem_rnw, mem_addr, req_dout); end
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        checks++; if (n_ready[0] != 0 || n_cancel != 0 || req_ready !== 3'b000) begin failures++; $display("FAIL rst_wait_quiet got ready=%0d cancel=%0d expected 0 0", n_ready[0], n_cancel); end
        send(1, 1'b1, 26'hB1, '0);
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 26'hB1) begin failures++; $display("FAIL rst_wait_next got %b/%h expected 1/b1", mem_req, mem_addr); end
        respond(1, 32'hB1B1);
        checks++; if (req_ready !== 3'b010 || req_dout !== 32'hB1B1) begin failures++; $display("FAIL rst_wait_ready got %b/%h expected 010/b1b1", req_ready, req_dout); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_cancel_read();
        test_cancel_write();
        test_cancel_vs_ready();
        test_cancel_pending();
        test_cancel_with_req();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule

// File: doc/gba_sdram_arbiter.md
GBA_SDRAM_ARBITER -- requirements
Module: gba_sdram_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, meaning the number of requester ports (fixed at 3 in this revision).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before an access is abandoned.
REQ-003 clk  in  1  system clock, ~100 MHz, the same clock as the SDRAM controller.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req  in  3  per-port one-cycle request pulse.
REQ-006 req_rnw  in  3  per-port: 1 = read, 0 = write.
REQ-007 req_addr  in  3x26  per-port address [26:1].
REQ-008 req_din  in  3x32  per-port write data.
REQ-009 req_cancel  in  3  per-port cancel pulse.
REQ-010 req_ready  out  3  per-port completion pulse.
REQ-011 req_dout  out  32  read data, shared by all ports, valid while req_ready is high.
REQ-012 req_overrun  out  3  per-port pulse: request dropped because one was already outstanding.
REQ-013 timeout_err  out  1  pulse: the in-flight access was abandoned on timeout.
REQ-014 mem_req, mem_rnw, mem_cancel  out  1 each  controller-side request, direction and cancel.
REQ-015 mem_addr  out  26  controller-side address.
REQ-016 mem_din  out  32  controller-side write data.
REQ-017 mem_ready, mem_ready16  in  1 each  controller completion (32-bit / 16-bit).
REQ-018 mem_dout  in  32  controller read data.

Function
REQ-019 Per port, a req pulse SHALL set a pending bit and capture addr/din/rnw in a port-local register; the bit stays set until the request is granted.
REQ-020 A req on a port that is already pending or in flight SHALL be dropped, and req_overrun[p] SHALL pulse in the following cycle.
REQ-021 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-022 In IDLE with any pending bit set, the arbiter SHALL grant round-robin: search starts at the port after last_grant, wrapping 2->0.
REQ-023 On grant, the arbiter SHALL clear the pending bit, latch the granted port, drive mem_addr/mem_din/mem_rnw from the captured registers, and go to ISSUE.
REQ-024 ISSUE SHALL assert mem_req for exactly one cycle and go to WAIT; mem_addr/mem_din/mem_rnw SHALL stay stable from ISSUE until WAIT exits.
REQ-025 In WAIT, mem_ready SHALL end the access: req_ready[grant] pulses one cycle later, with req_dout = mem_dout registered on that same edge; the FSM then returns to IDLE.
REQ-026 mem_ready16 SHALL be ignored.
REQ-027 Latency from req pulse to mem_req SHALL be 2 cycles when idle and uncontended (capture, then ISSUE).
REQ-028 req_cancel[p] on a pending, ungranted port SHALL clear its pending bit; no mem_req and no req_ready are produced.
REQ-029 req_cancel[grant] during WAIT on a read SHALL pulse mem_cancel one cycle, return to IDLE, and suppress req_ready.
REQ-030 req_cancel[grant] during WAIT on a write SHALL be ignored.
REQ-031 req_cancel in the same cycle as mem_ready SHALL win: no req_ready.
REQ-032 req_cancel and req in the same cycle on an idle port SHALL register the new request; the cancel has no effect.
REQ-033 A WAIT cycle counter SHALL saturate at TIMEOUT; on reaching it: pulse timeout_err, pulse mem_cancel, suppress req_ready, return to IDLE.
REQ-034 A new req on the granted port in the same cycle as its req_ready SHALL be accepted, not overrun.
REQ-035 last_grant SHALL update only on grant.

Reset
REQ-036 reset SHALL asynchronously force: state = IDLE, pending = 0, last_grant = 2, all pulse outputs 0, mem_addr/mem_din/req_dout = 0, mem_rnw = 1.
REQ-037 Reset during WAIT SHALL drop the in-flight access without req_ready, and SHALL NOT pulse mem_cancel (the controller is reset alongside).

Structure
REQ-038 A shared package SHALL hold the state enum (IDLE/ISSUE/WAIT), NREQ, the address width 26, and the data width 32.
REQ-039 One sub-module, gba_rr_pick, SHALL perform the combinational round-robin select from pending[2:0] and last_grant, outputting grant index and valid.

Verification
REQ-040 Single read port 0, addr 0x0001000, mem_ready 5 cycles after mem_req, mem_dout 0xDEADBEEF -> req_ready[0] once with req_dout 0xDEADBEEF, mem_req seen exactly once.
REQ-041 req on ports 0,1,2 in one cycle, last_grant = 2 -> grants in order 0,1,2, each after the previous mem_ready.
REQ-042 Port 1 read in WAIT, req_cancel[1] -> mem_cancel pulses, no req_ready[1], a pending port 2 is granted next.
REQ-043 Second req on port 0 while in flight -> req_overrun[0] one pulse, exactly one req_ready[0].
REQ-044 mem_ready withheld, TIMEOUT = 8 -> timeout_err after 8 WAIT cycles, mem_cancel pulse, FSM in IDLE.
REQ-045 reset asserted mid-WAIT, then released -> all outputs at reset values, no req_ready, the next request serviced normally.
